// File: rtl/roi_row_ctrl.sv
// Row-wise ROI detector: once armed, scans one frame, counts dark pixels per row and
// reports the first and last rows whose dark count reaches ROW_MIN.
module roi_row_ctrl #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int PIX_W      = 8,
   parameter int PIX_THRESH = 128,
   parameter int ROW_MIN    = 4,
   localparam int RW        = $clog2(V_ACTIVE)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic             iFrame_start,
   input  logic [PIX_W-1:0] iPixel,
   input  logic             iPix_val,
   input  logic             iAck,
   output logic             oBusy,
   output logic             oDone,
   output logic             oFound,
   output logic [RW-1:0]    oTop,
   output logic [RW-1:0]    oBottom
);

   localparam int CW = $clog2(H_ACTIVE);
   localparam int DW = $clog2(H_ACTIVE + 1);

   localparam logic [CW-1:0]    COL_LAST = CW'(H_ACTIVE - 1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(V_ACTIVE - 1);
   localparam logic [PIX_W-1:0] THRESH   = PIX_W'(PIX_THRESH);
   localparam logic [DW:0]      MIN_CNT  = (DW+1)'(ROW_MIN);

   typedef enum logic [1:0] {IDLE, ARM, SCAN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [DW-1:0] dark_cnt;
   logic          found;
   logic [RW-1:0] top;
   logic [RW-1:0] bottom;

   logic          dark;
   logic [DW:0]   total;

   always_comb begin
      dark  = 1'b0;
      total = '0;
      dark  = (iPixel < THRESH);
      total = {1'b0, dark_cnt} + (DW+1)'(dark);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         dark_cnt <= '0;
         found    <= 1'b0;
         top      <= '0;
         bottom   <= '0;
         oBusy    <= 1'b0;
         oDone    <= 1'b0;
         oFound   <= 1'b0;
         oTop     <= '0;
         oBottom  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (iStart) begin
                  state <= ARM;
                  oBusy <= 1'b1;
               end
            end
            ARM, SCAN: begin
               // A frame start (also mid-scan) restarts the frame; any pixel beside it is dropped.
               if (iFrame_start) begin
                  state    <= SCAN;
                  col      <= '0;
                  row      <= '0;
                  dark_cnt <= '0;
                  found    <= 1'b0;
                  top      <= '0;
                  bottom   <= '0;
               end else if (state == SCAN && iPix_val) begin
                  if (col != COL_LAST) begin
                     col      <= col + 1'b1;
                     dark_cnt <= total[DW-1:0];
                  end else begin
                     if (total >= MIN_CNT) begin
                        if (!found) top <= row;
                        bottom <= row;
                        found  <= 1'b1;
                     end
                     col      <= '0;
                     dark_cnt <= '0;
                     if (row == ROW_LAST) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               // The result is published one edge after the final pixel; ack only counts once visible.
               if (!oDone) begin
                  oDone   <= 1'b1;
                  oFound  <= found;
                  oTop    <= top;
                  oBottom <= bottom;
               end else if (iAck) begin
                  state <= IDLE;
                  oDone <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/roi_row_ctrl.md
Name: roi_row_ctrl

Overview:
- Frame-level controller that sequences row-wise region-of-interest (ROI) detection on the camera pixel stream.
- Armed by the host. Waits for a frame start, then scans one full frame and counts dark pixels in each row.
- Reports the first and last qualifying rows, then holds the result until the consumer acknowledges.
- Sits between the pixel stream (greyscale pixels with a valid strobe) and the downstream crop/classifier stage.

Parameters:
- H_ACTIVE, 640, active pixels per row.
- V_ACTIVE, 480, active rows per frame.
- PIX_W, 8, pixel width in bits.
- PIX_THRESH, 128, a pixel is "dark" when iPixel < PIX_THRESH (unsigned).
- ROW_MIN, 4, a row qualifies when its dark-pixel count >= ROW_MIN.

Ports:
- iCLK  in  1  pixel clock; all logic is on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle arm request; honoured only in IDLE.
- iFrame_start  in  1  one-cycle pulse preceding pixel (0,0) of a frame.
- iPixel  in  PIX_W  greyscale pixel.
- iPix_val  in  1  iPixel valid this cycle.
- iAck  in  1  consumer acknowledge of the result.
- oBusy  out  1  high in ARM and SCAN.
- oDone  out  1  result valid; held until iAck.
- oFound  out  1  at least one qualifying row was seen.
- oTop  out  RW  first qualifying row index, where RW = $clog2(V_ACTIVE).
- oBottom  out  RW  last qualifying row index.

Behaviour:
- Reset: iRST high forces the state to IDLE immediately (asynchronous). While iRST is high, all outputs, counters and internal flags are 0. Reset mid-frame abandons the scan with no partial result.
- Internal counters:
  - col, width $clog2(H_ACTIVE).
  - row, width RW.
  - dark_cnt, width $clog2(H_ACTIVE+1).
  - All counters saturate-free; they wrap explicitly as described below.
- States:
  - IDLE: oBusy=0, oDone=0. iStart -> ARM.
  - ARM: oBusy=1. On iFrame_start -> SCAN, and clear col, row, dark_cnt, found, top and bottom.
    - A pixel arriving in the same cycle as iFrame_start is ignored.
  - SCAN: oBusy=1. Each cycle with iPix_val=1 consumes one pixel:
    - Add dark = (iPixel < PIX_THRESH) to dark_cnt.
    - If col < H_ACTIVE-1: col <= col+1.
    - If col == H_ACTIVE-1 (end of row): evaluate total = dark_cnt + dark.
      - If total >= ROW_MIN: if found=0, set top <= row; always set bottom <= row and found <= 1.
      - Then col <= 0 and dark_cnt <= 0.
      - If row == V_ACTIVE-1 -> DONE; otherwise row <= row+1.
    - Cycles with iPix_val=0 hold all counters.
  - DONE: oBusy=0, oDone=1. oFound, oTop and oBottom are driven from the registered result and stay stable. iAck -> IDLE next cycle.
- Outputs oFound, oTop and oBottom:
  - Updated only on the SCAN -> DONE transition.
  - Retain their last values in IDLE and ARM until the next DONE.
- No-ROI frame: oFound=0, oTop=0, oBottom=0.
- Latency: oDone rises on the first clock edge after the edge that consumes the last pixel (V_ACTIVE-1, H_ACTIVE-1).
- Ignored inputs:
  - iFrame_start during SCAN restarts the scan: counters, found, top and bottom are cleared, and the state stays in SCAN.
  - iFrame_start in IDLE or DONE is ignored.
  - iStart outside IDLE is ignored.
  - iPix_val outside SCAN is ignored.
  - iAck outside DONE is ignored.
- Simultaneous iStart and iAck in DONE: iAck wins, go to IDLE. The iStart is dropped.
- A single qualifying row gives oTop == oBottom.
- Qualifying rows need not be contiguous; oBottom is the last qualifying row only.

Test Plan:
- Params H_ACTIVE=8, V_ACTIVE=6, ROW_MIN=2, PIX_THRESH=128. iStart, iFrame_start, 48 valid pixels with rows 2 and 4 each holding 3 pixels of 10 and all others 200 -> oDone one cycle after the 48th pixel; oFound=1, oTop=2, oBottom=4.
- Same params, all pixels 200 -> oDone=1, oFound=0, oTop=0, oBottom=0. iAck -> IDLE next cycle, oDone=0.
- Row 3 has exactly 1 dark pixel (below ROW_MIN), row 5 has exactly 2 with the second at col 7 -> oTop=5, oBottom=5 (end-of-row pixel counted).
- Random iPix_val gaps (50% duty) with the same image as scenario 1 -> identical result. Counters hold during gaps.
- iFrame_start reasserted after 20 pixels, then a full 48-pixel frame -> result reflects only the second frame. iRST pulsed mid-SCAN -> all outputs 0 and state IDLE immediately (asynchronous).
- iStart while in SCAN and iPix_val while in ARM -> no effect. In DONE, iAck and iStart together -> IDLE, not ARM.
